// File: rtl/fir_seq_ctrl.sv
// fir_seq_ctrl: 4-tap FIR sequencer that time-shares one 8x8 multiplier and one
//   16-bit accumulator across all taps. Each accepted sample takes one IDLE
//   accept edge plus exactly 4 MAC cycles; the result is then held in OUT.
// Latency: sample accepted at edge T -> yout_valid_o high after edge T+4.
// Backpressure: xin_ready_o is high only in IDLE. A result waits in OUT until
//   yout_ready_i is high. Samples offered outside IDLE are not buffered.
//
// Ports:
//   clk_i          system clock, all state updates on the rising edge
//   rst_ni         asynchronous active-low reset
//   xin_i          8-bit unsigned input sample
//   xin_valid_i    xin_i is presented
//   xin_ready_o    block accepts a sample this cycle (IDLE only)
//   coef_we_i      coefficient write strobe (honoured in IDLE only)
//   coef_addr_i    tap index 0..3 for the write
//   coef_data_i    8-bit unsigned coefficient value
//   coef_err_o     sticky: a coefficient write was dropped while busy
//   yout_o         16-bit filter result, keeps its value after being consumed
//   yout_valid_o   yout_o holds a completed result
//   yout_ready_i   consumer takes yout_o this cycle
//
// Build option: FIR_ACC_SAT_EN -- when defined the accumulator saturates at
//   16'hFFFF on overflow; when undefined it wraps modulo 2^16.

module fir_seq_ctrl #(
  parameter int TAPS = 4  // only 4 taps are supported
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [7:0]  xin_i,
  input  logic        xin_valid_i,
  output logic        xin_ready_o,
  input  logic        coef_we_i,
  input  logic [1:0]  coef_addr_i,
  input  logic [7:0]  coef_data_i,
  output logic        coef_err_o,
  output logic [15:0] yout_o,
  output logic        yout_valid_o,
  input  logic        yout_ready_i
);

  // The tap counter and coefficient address are 2 bits wide, which fixes the
  // tap count at 4.
  localparam logic [1:0] LAST_TAP = 2'(TAPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  k_q, k_d;
  logic [15:0] acc_q, acc_d;
  logic [7:0]  x_q [TAPS];
  logic [7:0]  x_d [TAPS];
  logic [7:0]  h_q [TAPS];
  logic [7:0]  h_d [TAPS];
  logic [15:0] yout_q, yout_d;
  logic        yout_valid_q, yout_valid_d;
  logic        coef_err_q, coef_err_d;

  // Shared datapath: one product per MAC cycle, selected by the tap counter.
  // x_q[0] is the newest sample, so tap k pairs h[k] with x[n-k].
  logic [15:0] prod_w;
  logic [15:0] acc_next_w;

  assign prod_w = {8'd0, h_q[k_q]} * {8'd0, x_q[k_q]};

`ifdef FIR_ACC_SAT_EN
  // All products are non-negative, so once the running sum clips it stays
  // clipped; the carry out of the 17-bit sum is the overflow indication.
  logic [16:0] sum_w;
  assign sum_w      = {1'b0, acc_q} + {1'b0, prod_w};
  assign acc_next_w = sum_w[16] ? 16'hFFFF : sum_w[15:0];
`else
  assign acc_next_w = acc_q + prod_w;
`endif

  // ---------------------------------------------------------------------------
  // Next-state and datapath control
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    acc_d        = acc_q;
    x_d          = x_q;
    h_d          = h_q;
    yout_d       = yout_q;
    yout_valid_d = yout_valid_q;
    coef_err_d   = coef_err_q;

    unique case (state_q)
      IDLE: begin
        // A write on the accept edge lands in h_q together with the new
        // sample, so the MAC that follows already sees the new coefficient.
        if (coef_we_i) begin
          h_d[coef_addr_i] = coef_data_i;
        end
        if (xin_valid_i) begin
          x_d[0] = xin_i;
          for (int i = 1; i < TAPS; i++) begin
            x_d[i] = x_q[i-1];
          end
          acc_d   = 16'd0;
          k_d     = 2'd0;
          state_d = MAC;
        end
      end

      MAC: begin
        acc_d = acc_next_w;
        k_d   = k_q + 2'd1;
        // The final product goes straight into the output register so the
        // result is visible on the same edge that enters OUT.
        if (k_q == LAST_TAP) begin
          yout_d       = acc_next_w;
          yout_valid_d = 1'b1;
          state_d      = OUT;
        end
        if (coef_we_i) begin
          coef_err_d = 1'b1;
        end
      end

      OUT: begin
        if (coef_we_i) begin
          coef_err_d = 1'b1;
        end
        if (yout_ready_i) begin
          yout_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end

      default: begin
        state_d      = IDLE;
        yout_valid_d = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers. Reset aborts any computation in flight and reloads the
  // default coefficients 1,2,3,4.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      k_q          <= 2'd0;
      acc_q        <= 16'd0;
      yout_q       <= 16'd0;
      yout_valid_q <= 1'b0;
      coef_err_q   <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        x_q[i] <= 8'd0;
        h_q[i] <= 8'(i + 1);
      end
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      acc_q        <= acc_d;
      yout_q       <= yout_d;
      yout_valid_q <= yout_valid_d;
      coef_err_q   <= coef_err_d;
      for (int i = 0; i < TAPS; i++) begin
        x_q[i] <= x_d[i];
        h_q[i] <= h_d[i];
      end
    end
  end

  assign xin_ready_o  = (state_q == IDLE);
  assign yout_o       = yout_q;
  assign yout_valid_o = yout_valid_q;
  assign coef_err_o   = coef_err_q;

endmodule

// File: doc/fir_seq_ctrl.md
FIR_SEQ_CTRL -- requirements
Module: fir_seq_ctrl

Interface
REQ-001 Parameter TAPS, default 4, number of taps sequenced per sample; only 4 is supported.
REQ-002 Clk  input  1  system clock, all state updates on rising edge.
REQ-003 Rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Xin  input  8  unsigned input sample.
REQ-005 Xin_valid  input  1  Xin is presented.
REQ-006 Xin_ready  output  1  block accepts a sample this cycle.
REQ-007 Coef_we  input  1  coefficient write strobe.
REQ-008 Coef_addr  input  2  tap index 0..3 for the write.
REQ-009 Coef_data  input  8  unsigned coefficient value.
REQ-010 Coef_err  output  1  sticky flag: a write was dropped because the block was busy.
REQ-011 Yout  output  16  filter result.
REQ-012 Yout_valid  output  1  Yout holds a completed result.
REQ-013 Yout_ready  input  1  consumer takes Yout this cycle.

Function
REQ-014 The block SHALL time-share one 8x8 unsigned multiplier and one 16-bit accumulator across all 4 taps: y = h0*x[n] + h1*x[n-1] + h2*x[n-2] + h3*x[n-3].
REQ-015 The FSM SHALL have three states: IDLE, MAC and OUT.
REQ-016 In IDLE, Xin_ready SHALL be 1; in MAC and OUT, Xin_ready SHALL be 0.
REQ-017 On Xin_valid && Xin_ready, the 4-entry delay line SHALL shift (x0<=Xin, x1<=x0, x2<=x1, x3<=x2), the accumulator SHALL clear, the tap counter SHALL load 0, and the state SHALL move to MAC.
REQ-018 In MAC, each cycle SHALL add h[k]*x[k] to the accumulator, where k is the tap counter value, and then increment k.
REQ-019 After the k=3 product is added, the state SHALL move to OUT.
REQ-020 MAC SHALL last exactly 4 cycles; with a sample accepted at edge T, Yout_valid SHALL rise after edge T+4.
REQ-021 In OUT, Yout and Yout_valid SHALL hold stable until Yout_ready=1; on that edge the state SHALL move to IDLE and Yout_valid SHALL drop.
REQ-022 Yout SHALL keep its last value after Yout_valid drops.
REQ-023 Products SHALL be 16-bit unsigned; accumulation SHALL wrap modulo 2^16 (see REQ-031).
REQ-024 A Coef_we in IDLE SHALL write h[Coef_addr] on that edge.
REQ-025 If Coef_we and an accepted sample occur on the same IDLE edge, the write SHALL take effect before the MAC that follows.
REQ-026 A Coef_we in MAC or OUT SHALL be dropped, SHALL set Coef_err, and SHALL leave the coefficients unchanged.
REQ-027 Xin_valid outside IDLE SHALL be ignored; no sample is buffered.

Reset
REQ-028 When Rst_n=0, the block SHALL immediately set state=IDLE, tap counter=0, accumulator=0, delay line all 0, Yout=0, Yout_valid=0 and Coef_err=0, and SHALL load coefficients h0..h3 = 1,2,3,4.
REQ-029 Reset asserted during MAC or OUT SHALL abort the computation; no partial result is ever presented.
REQ-030 The first accepted sample after Rst_n deasserts SHALL be processed normally.

Configuration
REQ-031 Macro FIR_ACC_SAT_EN: when defined, the accumulator SHALL saturate at 16'hFFFF on overflow; when undefined, it SHALL wrap modulo 2^16.

Verification
REQ-032 The bench SHALL cover these directed scenarios:
- Reset with default coefficients, then samples 10, 20 each drained immediately -> Yout=10, then Yout=40.
- Sample accepted at edge T with Yout_ready=1 -> Yout_valid high for exactly one cycle after edge T+4, and Xin_ready back to 1 one cycle later.
- Yout_ready held 0 for 10 cycles in OUT -> Yout stable, Xin_ready=0, and a Xin_valid pulse in that window does not shift the delay line.
- Coef_we (addr 2, data 9) during MAC -> Coef_err=1, and the result uses h2=3; the same write in IDLE -> the next result uses h2=9.
- All coefficients 255, samples 255, 255 -> second result 64514 with the macro undefined, 65535 with FIR_ACC_SAT_EN defined.
- Rst_n pulsed low in the 2nd MAC cycle -> all outputs 0, coefficients 1,2,3,4, delay line cleared; next sample 7 -> Yout=7.
